// File: rtl/uart_tx_fifo_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX FIFO write port
// between N_REQ byte streams, with a stall watchdog that frees a dead grant.
module uart_tx_fifo_arbiter #(
  parameter int DATA_SIZE   = 8,
  parameter int N_REQ       = 4,
  parameter int STALL_LIMIT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_SIZE-1:0] req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  output logic                       write_to_fifo,
  output logic [DATA_SIZE-1:0]       write_data_in,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       abort_pulse,
  output logic [CNT_W-1:0]           pkt_count,
  output logic [CNT_W-1:0]           abort_count
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                          state_q, state_d;
  logic [N_REQ-1:0]                grant_q, grant_d;
  logic [IW-1:0]                   gidx_q, gidx_d;
  logic [IW-1:0]                   last_q, last_d;
  logic [SW-1:0]                   stall_q, stall_d;
  logic [CNT_W-1:0]                pkt_q, pkt_d;
  logic [CNT_W-1:0]                abc_q, abc_d;
  logic                            abp_q, abp_d;

  logic [N_REQ-1:0][DATA_SIZE-1:0] data_arr;
  logic                            sel_found;
  logic [IW-1:0]                   sel_idx;
  logic                            xfer;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign data_arr[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
  end

  // Rotating priority: first valid requester after the previous owner.
  always_comb begin
    int cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!sel_found && req_valid[IW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    last_d        = last_q;
    stall_d       = stall_q;
    pkt_d         = pkt_q;
    abc_d         = abc_q;
    abp_d         = 1'b0;
    req_ready     = '0;
    write_to_fifo = 1'b0;
    write_data_in = '0;
    xfer          = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = BUSY;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
          gidx_d  = sel_idx;
          stall_d = '0;
        end
      end
      BUSY: begin
        write_data_in     = data_arr[gidx_q];
        req_ready[gidx_q] = ~fifo_full;
        xfer              = req_valid[gidx_q] & ~fifo_full;
        write_to_fifo     = xfer;
        if (xfer) begin
          stall_d = '0;
          if (req_last[gidx_q]) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = gidx_q;
            pkt_d   = pkt_q + 1'b1;
          end
        end else if (!req_valid[gidx_q]) begin
          // A full FIFO alone never ages the watchdog; only a silent owner does.
          if (stall_q == SW'(STALL_LIMIT - 1)) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = gidx_q;
            stall_d = '0;
            abp_d   = 1'b1;
            abc_d   = abc_q + 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!reset_n) begin
      req_ready     = '0;
      write_to_fifo = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(N_REQ - 1);
      stall_q <= '0;
      pkt_q   <= '0;
      abc_q   <= '0;
      abp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      pkt_q   <= pkt_d;
      abc_q   <= abc_d;
      abp_q   <= abp_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q == BUSY);
  assign abort_pulse = abp_q;
  assign pkt_count   = pkt_q;
  assign abort_count = abc_q;

endmodule

// File: tb/tb_uart_tx_fifo_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level
// model of ownership, stall age and wrapping counters.
module tb_uart_tx_fifo_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SL = 4;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0]   req_data;
  logic              fifo_full, write_to_fifo, busy, abort_pulse;
  logic [DW-1:0]     write_data_in;
  logic [CW-1:0]     pkt_count, abort_count;

  uart_tx_fifo_arbiter #(.DATA_SIZE(DW), .N_REQ(N), .STALL_LIMIT(SL), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .write_to_fifo(write_to_fifo), .write_data_in(write_data_in), .grant(grant),
    .busy(busy), .abort_pulse(abort_pulse), .pkt_count(pkt_count),
    .abort_count(abort_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stimulus for the next cycle
  logic [N-1:0] dv, dl;
  logic [DW-1:0] dd [N];
  logic df, dr;

  // Model: who owns the port (-1 = nobody), who owned it last, how many
  // consecutive cycles the owner has been silent, and the event counters.
  int m_owner, m_last, m_silent, m_pkts, m_aborts;
  bit m_abort_flag, m_known;

  task automatic step();
    logic [N-1:0] one, e_ready, e_grant;
    logic [DW-1:0] e_data;
    bit e_wr, done;
    int c;
    @(negedge clk);
    reset_n   = dr;
    req_valid = dv;
    req_last  = dl;
    fifo_full = df;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dd[i];
    #1;
    one = 1;
    e_ready = '0; e_grant = '0; e_data = '0; e_wr = 0;
    if (m_owner >= 0) begin
      e_grant = one << m_owner;
      e_data  = dd[m_owner];
      e_wr    = dv[m_owner] && !df;
      if (!df) e_ready = one << m_owner;
    end
    if (!dr) begin e_ready = '0; e_wr = 0; end
    chk("req_ready", req_ready, e_ready);
    chk("write_to_fifo", write_to_fifo, e_wr);
    if (m_known) begin
      chk("grant", grant, e_grant);
      chk("busy", busy, m_owner >= 0);
      chk("abort_pulse", abort_pulse, m_abort_flag);
      chk("pkt_count", pkt_count, m_pkts);
      chk("abort_count", abort_count, m_aborts);
      if (e_wr) chk("write_data_in", write_data_in, e_data);
    end
    @(posedge clk);
    m_abort_flag = 0;
    if (!dr) begin
      m_owner = -1; m_last = N - 1; m_silent = 0; m_pkts = 0; m_aborts = 0;
      m_known = 1;
    end else if (m_owner < 0) begin
      done = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!done && dv[c]) begin m_owner = c; m_silent = 0; done = 1; end
      end
    end else if (e_wr) begin
      m_silent = 0;
      if (dl[m_owner]) begin
        m_pkts = (m_pkts + 1) % (1 << CW);
        m_last = m_owner; m_owner = -1;
      end
    end else if (!dv[m_owner]) begin
      m_silent++;
      if (m_silent == SL) begin
        m_aborts = (m_aborts + 1) % (1 << CW);
        m_abort_flag = 1;
        m_last = m_owner; m_owner = -1; m_silent = 0;
      end
    end
  endtask

  task automatic do_reset();
    dr = 0; dv = '0; dl = '0; df = 0;
    step(); step();
    dr = 1;
  endtask

  initial begin
    m_owner = -1; m_last = N - 1; m_silent = 0; m_pkts = 0; m_aborts = 0;
    m_abort_flag = 0; m_known = 0;
    for (int i = 0; i < N; i++) dd[i] = '0;

    // Reset held with all requesters valid, then first grant goes to 0
    dr = 0; dv = '1; dl = '0; df = 0;
    step(); step();
    dr = 1; step(); step(); step();

    // Single 3-byte packet from requester 2
    do_reset();
    dv = 4'b0100; dl = '0; dd[2] = 8'h41; step();
    step();
    dd[2] = 8'h42; step();
    dd[2] = 8'h43; dl = 4'b0100; step();
    dv = '0; dl = '0; step(); step();

    // Round-robin with 1-byte packets from all requesters
    do_reset();
    dv = '1; dl = '1;
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < N; j++) dd[j] = DW'($urandom);
      step();
    end

    // Backpressure mid-packet must not age the watchdog
    do_reset();
    dv = 4'b0001; dl = '0; dd[0] = 8'h10; step(); step();
    df = 1; dd[0] = 8'h11;
    repeat (10) step();
    df = 0; step();
    dd[0] = 8'h12; dl = 4'b0001; step();
    dv = '0; dl = '0; step();

    // Watchdog: requester 1 goes silent with 3 pending
    do_reset();
    dv = 4'b0010; dl = '0; dd[1] = 8'hA0; step();
    step(); dd[1] = 8'hA1; step();
    dv = 4'b1000; dd[3] = 8'h33;
    repeat (6) step();
    dl = 4'b1000; step();
    dv = '0; dl = '0; step();

    // Randomized traffic with varying density
    do_reset();
    for (int e = 0; e < 20; e++) begin
      int dens;
      dens = $urandom_range(1, 9);
      repeat (150) begin
        for (int j = 0; j < N; j++) begin
          dv[j] = ($urandom_range(0, 9) < dens);
          dl[j] = ($urandom_range(0, 3) == 0);
          dd[j] = DW'($urandom);
        end
        df = ($urandom_range(0, 4) == 0);
        dr = ($urandom_range(0, 299) != 0);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_arbiter.md
Name: uart_tx_fifo_arbiter

Overview:
- Shares the single UART TX FIFO write port between N_REQ byte-stream requesters: logger, command echo, status reporter, etc.
- Round-robin arbitration at packet granularity; the grant is held until the requester's last byte is written.
- Writes are gated by the FIFO full flag.
- A stall watchdog releases a grant when the granted requester stops supplying bytes.
- Sits between the requesters and the FIFO write side; the UART transmitter drains the FIFO.

Parameters:
- DATA_SIZE, 8: bits per data word; must match the FIFO.
- N_REQ, 4: number of requesters, 2..8.
- STALL_LIMIT, 255: consecutive BUSY cycles with the granted req_valid low before forced release, >=1.
- CNT_W, 16: width of the packet and abort counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  N_REQ*DATA_SIZE  per-requester byte; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- req_last  in  N_REQ  marks the final byte of a packet; qualified by req_valid.
- req_ready  out  N_REQ  byte accepted this cycle when valid&ready.
- fifo_full  in  1  FIFO full flag.
- write_to_fifo  out  1  FIFO write strobe.
- write_data_in  out  DATA_SIZE  FIFO write data.
- grant  out  N_REQ  one-hot current owner; all zero when IDLE.
- busy  out  1  a grant is active.
- abort_pulse  out  1  one-cycle pulse on watchdog release.
- pkt_count  out  CNT_W  completed packets, wraps.
- abort_count  out  CNT_W  watchdog releases, wraps.

Behaviour:
- Reset is sampled only on the clk rising edge while reset_n=0, and overrides all other activity that edge, including a mid-packet grant with no flush.
- Reset values:
  - state=IDLE, grant=0, busy=0, abort_pulse=0.
  - pkt_count=0, abort_count=0, stall counter=0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
- Combinational outputs while reset_n=0: req_ready=0, write_to_fifo=0.
- States: IDLE, BUSY.
- IDLE:
  - req_ready=0, write_to_fifo=0.
  - If any req_valid is high, select the first set bit searching last_grant+1, last_grant+2, ... with modulo N_REQ wrap.
  - Register grant one-hot, set busy, go to BUSY. Arbitration latency is 1 cycle; no byte is transferred in the arbitration cycle.
- BUSY, with g = granted index:
  - req_ready[g] = ~fifo_full. All other req_ready bits are 0.
  - write_to_fifo = req_valid[g] & ~fifo_full, combinational. The FIFO full flag is registered, so the strobe never asserts while full=1.
  - write_data_in = req_data slice g, combinational mux. When IDLE it is don't-care; drive it to 0.
  - Transfer with req_last[g]=1: next state IDLE, last_grant=g, grant=0, pkt_count+1. The next arbitration starts in the following IDLE cycle, so there is 1 dead cycle between packets.
  - Transfer with req_last[g]=0: stay in BUSY, stall counter cleared.
- Stall counter:
  - Increments on each BUSY cycle with req_valid[g]=0.
  - Holds, without incrementing, on cycles blocked only by fifo_full.
  - Clears on every transfer and on entry to BUSY.
- Watchdog: when the counter is at STALL_LIMIT-1 and req_valid[g]=0:
  - Next state IDLE, abort_pulse=1 for exactly one cycle, abort_count+1.
  - last_grant=g, so the stalled requester loses priority.
  - Bytes already written stay in the FIFO; no trailer is inserted.
- Lower-numbered requesters get no preference within round-robin. A requester dropping req_valid in IDLE before arbitration simply is not chosen.
- Counters wrap modulo 2^CNT_W with no saturation.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with all req_valid=1 -> grant=0, write_to_fifo=0, counters 0. After release, grant=0001 one cycle later.
- Single packet: requester 2 sends 0x41,0x42,0x43 with last on 0x43, fifo_full=0 -> three consecutive strobes with data 41,42,43. Next cycle grant=0, pkt_count=1.
- Round-robin: all four valid continuously, 1-byte packets -> grant order 0,1,2,3,0 with 1 idle cycle between each. pkt_count=5 after 5 packets.
- Full backpressure: fifo_full=1 for 10 cycles mid-packet -> no strobe, req_ready=0, no abort even with STALL_LIMIT=4. After full drops, the packet resumes with the next byte.
- Watchdog: STALL_LIMIT=4, requester 1 sends 2 bytes then drops valid -> abort_pulse on the 4th stall cycle, abort_count=1. Requester 3 (pending) is granted next.
- Wrap: CNT_W=2, complete 5 packets -> pkt_count sequence 1,2,3,0,1.
